// File: rtl/stack_seq_pkg.sv
// Shared encodings for the stack sequencer: opcodes, FSM states and SP reset value.
// Optional guard logic is enabled with the STACK_GUARD_EN macro.
package stack_seq_pkg;

    typedef enum logic [1:0] {
        OP_CALL = 2'b00,
        OP_RET  = 2'b01,
        OP_INT  = 2'b10,
        OP_RETI = 2'b11
    } op_t;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_FL,
        POP_FL,
        POP_LO,
        POP_HI,
        FIN
    } state_t;

    // All-ones; modules slice this to their own address width.
    localparam logic [31:0] SP_RESET = '1;

endpackage

// File: rtl/stack_pointer.sv
// Stack pointer register with push/pop update and optional overflow/underflow guard.
// Guard behaviour is compiled in with the STACK_GUARD_EN macro.
module stack_pointer
    import stack_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    output logic [ADDR_W-1:0] sp,
    output logic              blocked,
    output logic              stack_err
);

    localparam logic [ADDR_W-1:0] SP_INIT = SP_RESET[ADDR_W-1:0];

`ifdef STACK_GUARD_EN
    assign blocked = (push && (sp == '0)) || (pop && (sp == SP_INIT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stack_err <= 1'b0;
        end else if (blocked) begin
            stack_err <= 1'b1;
        end
    end
`else
    assign blocked   = 1'b0;
    assign stack_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp <= SP_INIT;
        end else if (!blocked) begin
            if (push) begin
                sp <= sp - 1'b1;
            end else if (pop) begin
                sp <= sp + 1'b1;
            end
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-cycle CALL/RET/INT/RETI stack sequencer driving the data-memory port.
// Define STACK_GUARD_EN to enable stack overflow/underflow protection.
module stack_sequencer
    import stack_seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 11,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned PC_W   = 32,
    parameter int unsigned FLAG_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    output logic              ack,
    input  logic [PC_W-1:0]   pc_in,
    input  logic [FLAG_W-1:0] flags_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [PC_W-1:0]   pc_out,
    output logic              pc_load,
    output logic [FLAG_W-1:0] flags_out,
    output logic              flags_load,
    output logic [ADDR_W-1:0] sp,
    output logic              stack_err
);

    state_t              state;
    op_t                 op_q;
    logic [PC_W-1:0]     pc_q;
    logic [FLAG_W-1:0]   fl_q;
    logic [DATA_W-1:0]   lo_cap;
    logic [FLAG_W-1:0]   fl_cap;
    logic                rd_valid;
    logic [PC_W-1:0]     pc_reg;
    logic [FLAG_W-1:0]   fl_reg;
    logic [DATA_W-1:0]   rd_data;
    logic                push_st;
    logic                pop_st;
    logic                blocked;

    assign push_st = (state == PUSH_HI) || (state == PUSH_LO) || (state == PUSH_FL);
    assign pop_st  = (state == POP_FL) || (state == POP_LO) || (state == POP_HI);

    stack_pointer #(.ADDR_W(ADDR_W)) u_sp (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_st),
        .pop       (pop_st),
        .sp        (sp),
        .blocked   (blocked),
        .stack_err (stack_err)
    );

    assign ack    = (state == IDLE) && start;
    assign busy   = (state != IDLE) || ack;
    assign mem_we = push_st && !blocked;
    assign mem_re = pop_st && !blocked;

    // A suppressed read leaves mem_rdata stale, so captures must see zero instead.
    assign rd_data = rd_valid ? mem_rdata : '0;

    always_comb begin
        mem_addr = '0;
        if (push_st) begin
            mem_addr = sp;
        end else if (pop_st) begin
            mem_addr = sp + 1'b1;
        end
    end

    always_comb begin
        mem_wdata = '0;
        case (state)
            PUSH_HI: mem_wdata = pc_q[PC_W-1:DATA_W];
            PUSH_LO: mem_wdata = pc_q[DATA_W-1:0];
            PUSH_FL: mem_wdata = DATA_W'(fl_q);
            default: mem_wdata = '0;
        endcase
    end

    assign done       = ((state == PUSH_LO) && (op_q == OP_CALL)) || (state == PUSH_FL) || (state == FIN);
    assign pc_load    = (state == FIN);
    assign flags_load = (state == FIN) && (op_q == OP_RETI);

    // The hi word arrives in FIN itself, so the loaded value bypasses the hold register.
    assign pc_out    = pc_load    ? {rd_data, lo_cap} : pc_reg;
    assign flags_out = flags_load ? fl_cap            : fl_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            op_q     <= OP_CALL;
            pc_q     <= '0;
            fl_q     <= '0;
            lo_cap   <= '0;
            fl_cap   <= '0;
            rd_valid <= 1'b0;
            pc_reg   <= '0;
            fl_reg   <= '0;
        end else begin
            rd_valid <= mem_re;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op_t'(op);
                        pc_q <= pc_in;
                        fl_q <= flags_in;
                        case (op_t'(op))
                            OP_CALL, OP_INT: state <= PUSH_HI;
                            OP_RET:          state <= POP_LO;
                            default:         state <= POP_FL;
                        endcase
                    end
                end
                PUSH_HI: state <= PUSH_LO;
                PUSH_LO: state <= (op_q == OP_INT) ? PUSH_FL : IDLE;
                PUSH_FL: state <= IDLE;
                POP_FL:  state <= POP_LO;
                POP_LO: begin
                    if (op_q == OP_RETI) begin
                        fl_cap <= rd_data[FLAG_W-1:0];
                    end
                    state <= POP_HI;
                end
                POP_HI: begin
                    lo_cap <= rd_data;
                    state  <= FIN;
                end
                FIN: begin
                    pc_reg <= pc_out;
                    if (op_q == OP_RETI) begin
                        fl_reg <= fl_cap;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Self-checking bench for stack_sequencer: vector table, memory-traffic scoreboard, corner sequences.
// Expectations follow STACK_GUARD_EN when it is defined for the build.
module tb_stack_sequencer;
    import stack_seq_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic        ack;
    logic [31:0] pc_in;
    logic [2:0]  flags_in;
    logic [10:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] mem_rdata;
    logic        busy;
    logic        done;
    logic [31:0] pc_out;
    logic        pc_load;
    logic [2:0]  flags_out;
    logic        flags_load;
    logic [10:0] sp;
    logic        stack_err;

    int tests = 0;
    int fails = 0;

    stack_sequencer #(.ADDR_W(11), .DATA_W(16), .PC_W(32), .FLAG_W(3)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .ack(ack),
        .pc_in(pc_in), .flags_in(flags_in), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .busy(busy), .done(done),
        .pc_out(pc_out), .pc_load(pc_load), .flags_out(flags_out), .flags_load(flags_load),
        .sp(sp), .stack_err(stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model with a preload port used only while the DUT is idle.
    logic [15:0] mem [2048];
    logic        pre_en;
    logic [10:0] pre_addr;
    logic [15:0] pre_data;

    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            if (mem_re) mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [10:0] addr;
        logic [15:0] data;
    } sb_t;

    sb_t         sb[$];
    logic [10:0] mdl_sp;

    task automatic sb_push(input logic we, input logic [10:0] addr, input logic [15:0] data);
        sb_t e;
        e.we = we; e.addr = addr; e.data = data;
        sb.push_back(e);
    endtask

    task automatic sb_expect(input logic [1:0] o, input logic [31:0] pc, input logic [2:0] fl);
        case (o)
            2'b00: begin
                sb_push(1'b1, mdl_sp, pc[31:16]);
                sb_push(1'b1, mdl_sp - 11'd1, pc[15:0]);
                mdl_sp = mdl_sp - 11'd2;
            end
            2'b10: begin
                sb_push(1'b1, mdl_sp, pc[31:16]);
                sb_push(1'b1, mdl_sp - 11'd1, pc[15:0]);
                sb_push(1'b1, mdl_sp - 11'd2, {13'd0, fl});
                mdl_sp = mdl_sp - 11'd3;
            end
            2'b01: begin
                sb_push(1'b0, mdl_sp + 11'd1, 16'h0);
                sb_push(1'b0, mdl_sp + 11'd2, 16'h0);
                mdl_sp = mdl_sp + 11'd2;
            end
            default: begin
                sb_push(1'b0, mdl_sp + 11'd1, 16'h0);
                sb_push(1'b0, mdl_sp + 11'd2, 16'h0);
                sb_push(1'b0, mdl_sp + 11'd3, 16'h0);
                mdl_sp = mdl_sp + 11'd3;
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (mem_we || mem_re) begin
                chk("we_re_exclusive", {63'd0, mem_we & mem_re}, 64'd0);
                if (sb.size() == 0) begin
                    chk("sb_unexpected_access", {62'd0, mem_we, mem_re}, 64'd0);
                end else begin
                    sb_t e;
                    e = sb.pop_front();
                    chk("sb_we", {63'd0, mem_we}, {63'd0, e.we});
                    chk("sb_addr", {53'd0, mem_addr}, {53'd0, e.addr});
                    if (e.we) chk("sb_wdata", {48'd0, mem_wdata}, {48'd0, e.data});
                end
            end
            if (!busy) chk("addr_idle", {53'd0, mem_addr}, 64'd0);
        end
    end

    task automatic reset_checks(input string tag);
        chk({tag, "_sp"}, {53'd0, sp}, 64'h7FF);
        chk({tag, "_busy"}, {63'd0, busy}, 64'd0);
        chk({tag, "_strobes"}, {59'd0, mem_we, mem_re, done, pc_load, flags_load}, 64'd0);
        chk({tag, "_pc_out"}, {32'd0, pc_out}, 64'd0);
        chk({tag, "_flags_out"}, {61'd0, flags_out}, 64'd0);
        chk({tag, "_stack_err"}, {63'd0, stack_err}, 64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        reset_checks("reset");
        repeat (2) @(negedge clk);
        rst_n  = 1'b1;
        mdl_sp = 11'h7FF;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] pc, input logic [2:0] fl,
                          input int exp_cyc, input logic [10:0] exp_sp,
                          input logic [31:0] exp_pc, input logic [2:0] exp_fl, input bit use_sb);
        int  cyc;
        int  bcnt;
        bit  got;
        bit  is_pop;
        is_pop = (o == OP_RET) || (o == OP_RETI);
        if (use_sb) sb_expect(o, pc, fl);
        @(negedge clk);
        start = 1'b1; op = o; pc_in = pc; flags_in = fl;
        #1;
        chk("ack_accept", {63'd0, ack}, 64'd1);
        chk("busy_accept", {63'd0, busy}, 64'd1);
        cyc = 0; bcnt = 0; got = 0;
        while (!got && cyc < 8) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            cyc++;
            if (busy) bcnt++;
            if (ack) chk("ack_while_busy", {63'd0, ack}, 64'd0);
            if (done) begin
                got = 1;
                chk("pc_load_at_done", {63'd0, pc_load}, {63'd0, is_pop});
                chk("flags_load_at_done", {63'd0, flags_load}, {63'd0, o == OP_RETI});
                if (is_pop) chk("pc_out_at_fin", {32'd0, pc_out}, {32'd0, exp_pc});
                if (o == OP_RETI) chk("flags_out_at_fin", {61'd0, flags_out}, {61'd0, exp_fl});
            end
        end
        chk("done_cycle", cyc, exp_cyc);
        chk("busy_cycles", bcnt, exp_cyc);
        @(negedge clk);
        #1;
        chk("sp_after", {53'd0, sp}, {53'd0, exp_sp});
        chk("idle_after", {61'd0, busy, done, pc_load}, 64'd0);
        if (is_pop) chk("pc_out_hold", {32'd0, pc_out}, {32'd0, exp_pc});
    endtask

    typedef struct {
        logic [1:0]  op;
        logic [31:0] pc;
        logic [2:0]  fl;
        int          cyc;
        logic [10:0] sp;
        logic [31:0] pc_exp;
        logic [2:0]  fl_exp;
    } vec_t;

    vec_t vt[8];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int first_done;
        int second_ack;
        int stray;
        int loads;

        vt[0] = '{OP_INT,  32'hABCD_0010, 3'b101, 3, 11'h7FC, 32'h0,          3'b000};
        vt[1] = '{OP_RETI, 32'h0,         3'b000, 4, 11'h7FF, 32'hABCD_0010, 3'b101};
        vt[2] = '{OP_CALL, 32'h0001_2345, 3'b000, 2, 11'h7FD, 32'h0,          3'b000};
        vt[3] = '{OP_CALL, 32'hDEAD_BEEF, 3'b000, 2, 11'h7FB, 32'h0,          3'b000};
        vt[4] = '{OP_INT,  32'h1234_0000, 3'b010, 3, 11'h7F8, 32'h0,          3'b000};
        vt[5] = '{OP_RETI, 32'h0,         3'b000, 4, 11'h7FB, 32'h1234_0000, 3'b010};
        vt[6] = '{OP_RET,  32'h0,         3'b000, 3, 11'h7FD, 32'hDEAD_BEEF, 3'b000};
        vt[7] = '{OP_RET,  32'h0,         3'b000, 3, 11'h7FF, 32'h0001_2345, 3'b000};

        rst_n = 1'b0; start = 1'b0; op = 2'b00; pc_in = '0; flags_in = '0;
        pre_en = 1'b0; pre_addr = '0; pre_data = '0; mdl_sp = 11'h7FF;

        @(negedge clk);
        pre_en = 1'b1; pre_addr = 11'h000; pre_data = 16'h1111;
        @(negedge clk);
        pre_addr = 11'h001; pre_data = 16'h2222;
        @(negedge clk);
        pre_en = 1'b0;
        reset_checks("init");
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        reset_checks("post_reset");

        for (int i = 0; i < 8; i++) begin
            run_op(vt[i].op, vt[i].pc, vt[i].fl, vt[i].cyc, vt[i].sp, vt[i].pc_exp, vt[i].fl_exp, 1'b1);
        end

        // Two RETs with start held continuously.
        run_op(OP_CALL, 32'h1111_2222, 3'b000, 2, 11'h7FD, 32'h0, 3'b000, 1'b1);
        run_op(OP_CALL, 32'h3333_4444, 3'b000, 2, 11'h7FB, 32'h0, 3'b000, 1'b1);
        sb_expect(OP_RET, 32'h0, 3'b000);
        sb_expect(OP_RET, 32'h0, 3'b000);
        @(negedge clk);
        start = 1'b1; op = OP_RET;
        #1;
        chk("b2b_ack1", {63'd0, ack}, 64'd1);
        cyc = 0; first_done = -1; second_ack = -1; stray = 0;
        while (second_ack < 0 && cyc < 12) begin
            @(negedge clk);
            #1;
            cyc++;
            if (ack) begin
                if (first_done < 0) stray++;
                else second_ack = cyc;
            end
            if (done && first_done < 0) begin
                first_done = cyc;
                chk("b2b_pc1", {32'd0, pc_out}, 64'h3333_4444);
            end
        end
        chk("b2b_first_done", first_done, 3);
        chk("b2b_second_ack", second_ack, 4);
        chk("b2b_stray_ack", stray, 0);
        cyc = 0;
        while (cyc < 8) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            cyc++;
            if (done) break;
        end
        chk("b2b_done2_cycle", cyc, 3);
        chk("b2b_pc2", {32'd0, pc_out}, 64'h1111_2222);
        @(negedge clk);
        #1;
        chk("b2b_sp", {53'd0, sp}, 64'h7FF);

        // RET from an empty stack.
        do_reset();
`ifdef STACK_GUARD_EN
        run_op(OP_RET, 32'h0, 3'b000, 3, 11'h7FF, 32'h0, 3'b000, 1'b0);
        chk("guard_stack_err", {63'd0, stack_err}, 64'd1);
`else
        run_op(OP_RET, 32'h0, 3'b000, 3, 11'h001, 32'h2222_1111, 3'b000, 1'b1);
        chk("wrap_stack_err", {63'd0, stack_err}, 64'd0);
`endif

        // Reset asserted during POP_HI of a RET.
        do_reset();
        run_op(OP_CALL, 32'h5555_AAAA, 3'b000, 2, 11'h7FD, 32'h0, 3'b000, 1'b1);
        sb_expect(OP_RET, 32'h0, 3'b000);
        @(negedge clk);
        start = 1'b1; op = OP_RET;
        #1;
        chk("abort_ack", {63'd0, ack}, 64'd1);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("abort");
        loads = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        mdl_sp = 11'h7FF;
        repeat (4) begin
            @(negedge clk);
            #1;
            if (pc_load) loads++;
        end
        chk("abort_no_pc_load", loads, 0);
        chk("abort_sp", {53'd0, sp}, 64'h7FF);
        chk("sb_drained", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
